// File: rtl/mm_r2mm_unroll.sv
`default_nettype none
// mm_r2mm_unroll: radix-2 Montgomery multiplier, res = x*y*2^-K mod m.
// Consumes U bits of x per clock through U chained iteration stages.
module mm_r2mm_unroll #(
  parameter int K = 2048,
  parameter int U = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_i,
  input  logic         clr_i,
  input  logic [K-1:0] x_i,
  input  logic [K-1:0] y_i,
  input  logic [K-1:0] m_i,
  output logic         busy_o,
  output logic [K-1:0] res_o,
  output logic         val_o
);

  localparam int ITER = K / U;
  localparam int CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  xr_q, xr_d;
  logic [K-1:0]  yr_q, yr_d;
  logic [K-1:0]  mr_q, mr_d;
  logic [K-1:0]  res_q, res_d;
  logic [K:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          val_q, val_d;

  logic [U-1:0]  w_xbits;
  logic [K:0]    w_s_iter;
  logic [K+1:0]  w_t;
  logic [K+1:0]  w_u;
  logic          w_ge;
  logic [K:0]    w_sub;
  logic          w_unused;

  // U chained iterations; K+2 bits holds s + y + m without truncation.
  always_comb begin
    w_xbits  = U'(xr_q >> (U * int'(cnt_q)));
    w_s_iter = s_q;
    w_t      = '0;
    w_u      = '0;
    for (int j = 0; j < U; j++) begin
      w_t      = {1'b0, w_s_iter} + (w_xbits[j] ? {2'b00, yr_q} : '0);
      w_u      = w_t + (w_t[0] ? {2'b00, mr_q} : '0);
      w_s_iter = w_u[K+1:1];
    end
  end

  assign w_ge     = (s_q >= {1'b0, mr_q});
  assign w_sub    = s_q - {1'b0, mr_q};
  assign w_unused = ^{w_u[0], w_sub[K]};

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    mr_d    = mr_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    val_d   = 1'b0;
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            xr_d    = x_i;
            yr_d    = y_i;
            mr_d    = m_i;
            s_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          s_d   = w_s_iter;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIN;
        end
        FIN: begin
          res_d   = w_ge ? w_sub[K-1:0] : s_q[K-1:0];
          val_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      mr_q    <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      mr_q    <= mr_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      val_q   <= val_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign res_o  = res_q;
  assign val_o  = val_q;

endmodule
`default_nettype wire
